tt_um_hoene_input_arbiter: RTL and testbench

//  Chooses which decoded input stream (DIN or BIN) drives tt_um_hoene_protocol_select.

---
 rtl/tt_um_hoene_input_arbiter_pkg.sv | 17 +
 rtl/tt_um_hoene_idle_timer.sv | 34 +++
 rtl/tt_um_hoene_input_arbiter.sv | 179 +++++++++++++++++
 tb/tb_tt_um_hoene_input_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_input_arbiter_pkg.sv
// Shared definitions for the input arbiter.
// Holds the arbiter state encoding and the word geometry that
// tt_um_hoene_protocol_select also relies on.
package tt_um_hoene_input_arbiter_pkg;

    // Arbiter states; encodings are shared with protocol_select
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned CNT_W     = $clog2(WORD_BITS);

endpackage

// File: rtl/tt_um_hoene_idle_timer.sv
// Saturating TW-bit up-counter shared by the idle timeout and the hold-off gap.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force the count to 0 (wins over en)
//   en        : count up by one while below limit
//   limit     : terminal value; the count saturates here
//   expired   : count == limit (combinational)
module tt_um_hoene_idle_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] limit,
    output logic          expired
);

    logic [TW-1:0] r_count;
    logic          w_expired;

    assign w_expired = (r_count == limit);
    assign expired   = w_expired;

    // Count register; holds at the terminal value instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && !w_expired) begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule

// File: rtl/tt_um_hoene_input_arbiter.sv
// Selects DIN or BIN as the source for protocol_select, locking onto the first
// stream that strobes with sync and holding it until sync loss or idle timeout,
// followed by a hold-off gap before re-arbitration.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   din_data/din_clk/din_sync    : DIN decoder bit, strobe, lock
//   bin_data/bin_clk/bin_sync    : BIN decoder bit, strobe, lock
//   out_data/out_clk/out_sync    : selected bit, strobe, stream valid (registered)
//   in0selected                  : DIN owns the lock (registered)
//   bit_counter[4:0]             : bit index within the word for out_clk (registered)
//   frame_error                  : one-cycle pulse when the lock drops mid-word
module tt_um_hoene_input_arbiter
    import tt_um_hoene_input_arbiter_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 255,
    parameter int unsigned HOLDOFF      = 16,
    parameter int unsigned TW           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_data,
    input  logic             din_clk,
    input  logic             din_sync,
    input  logic             bin_data,
    input  logic             bin_clk,
    input  logic             bin_sync,
    output logic             out_data,
    output logic             out_clk,
    output logic             out_sync,
    output logic             in0selected,
    output logic [CNT_W-1:0] bit_counter,
    output logic             frame_error
);

    localparam logic [TW-1:0] LIM_IDLE = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] LIM_HOLD = TW'(HOLDOFF - 1);

    state_t            r_state,       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,         w_cnt_nxt;
    logic [CNT_W-1:0]  r_bit_counter, w_bc_nxt;
    logic              r_out_data,    w_data_nxt;
    logic              r_out_clk,     w_clk_nxt;
    logic              r_out_sync,    w_sync_nxt;
    logic              r_in0,         w_in0_nxt;
    logic              r_ferr,        w_ferr_nxt;

    logic              w_timer_clr;
    logic              w_timer_en;
    logic              w_timer_exp;
    logic [TW-1:0]     w_timer_lim;
    logic              w_own_data;
    logic              w_own_clk;
    logic              w_own_sync;

    // One timer serves both the idle timeout and the hold-off; they never overlap
    assign w_timer_lim = (r_state == ST_HOLD) ? LIM_HOLD : LIM_IDLE;

    tt_um_hoene_idle_timer #(
        .TW (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_timer_clr),
        .en      (w_timer_en),
        .limit   (w_timer_lim),
        .expired (w_timer_exp)
    );

    // Owning stream in the lock states
    assign w_own_data = (r_state == ST_LOCK0) ? din_data : bin_data;
    assign w_own_clk  = (r_state == ST_LOCK0) ? din_clk  : bin_clk;
    assign w_own_sync = (r_state == ST_LOCK0) ? din_sync : bin_sync;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bit_counter <= '0;
            r_out_data    <= 1'b0;
            r_out_clk     <= 1'b0;
            r_out_sync    <= 1'b0;
            r_in0         <= 1'b0;
            r_ferr        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bit_counter <= w_bc_nxt;
            r_out_data    <= w_data_nxt;
            r_out_clk     <= w_clk_nxt;
            r_out_sync    <= w_sync_nxt;
            r_in0         <= w_in0_nxt;
            r_ferr        <= w_ferr_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bc_nxt    = r_bit_counter;
        w_data_nxt  = r_out_data;
        w_clk_nxt   = 1'b0;
        w_sync_nxt  = 1'b0;
        w_in0_nxt   = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_timer_clr = 1'b1;
                w_cnt_nxt   = '0;
                w_bc_nxt    = '0;
                // Starting strobe is forwarded on the lock transition; DIN wins ties
                if (din_sync && din_clk) begin
                    w_state_nxt = ST_LOCK0;
                    w_data_nxt  = din_data;
                    w_clk_nxt   = 1'b1;
                    w_sync_nxt  = 1'b1;
                    w_in0_nxt   = 1'b1;
                    w_bc_nxt    = r_cnt;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else if (bin_sync && bin_clk) begin
                    w_state_nxt = ST_LOCK1;
                    w_data_nxt  = bin_data;
                    w_clk_nxt   = 1'b1;
                    w_sync_nxt  = 1'b1;
                    w_bc_nxt    = r_cnt;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

            ST_LOCK0, ST_LOCK1: begin
                w_timer_en = 1'b1;
                // Sync loss beats a same-cycle strobe; a strobe beats the timeout
                if (!w_own_sync || (!w_own_clk && w_timer_exp)) begin
                    w_state_nxt = ST_HOLD;
                    w_ferr_nxt  = (r_cnt != '0);
                    w_cnt_nxt   = '0;
                    w_bc_nxt    = '0;
                    w_timer_clr = 1'b1;
                end else begin
                    w_sync_nxt = 1'b1;
                    w_in0_nxt  = (r_state == ST_LOCK0);
                    if (w_own_clk) begin
                        w_data_nxt  = w_own_data;
                        w_clk_nxt   = 1'b1;
                        w_bc_nxt    = r_cnt;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_timer_clr = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                w_timer_en = 1'b1;
                w_cnt_nxt  = '0;
                w_bc_nxt   = '0;
                if (w_timer_exp) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_clr = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_data    = r_out_data;
    assign out_clk     = r_out_clk;
    assign out_sync    = r_out_sync;
    assign in0selected = r_in0;
    assign bit_counter = r_bit_counter;
    assign frame_error = r_ferr;

endmodule

// File: tb/tb_tt_um_hoene_input_arbiter.sv
// Directed bench for tt_um_hoene_input_arbiter.
module tb_tt_um_hoene_input_arbiter;

    logic       clk;
    logic       rst;
    logic       din_data, din_clk, din_sync;
    logic       bin_data, bin_clk, bin_sync;
    logic       out_data, out_clk, out_sync, in0selected, frame_error;
    logic [4:0] bit_counter;

    int checks;
    int errors;

    tt_um_hoene_input_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .din_data    (din_data),
        .din_clk     (din_clk),
        .din_sync    (din_sync),
        .bin_data    (bin_data),
        .bin_clk     (bin_clk),
        .bin_sync    (bin_sync),
        .out_data    (out_data),
        .out_clk     (out_clk),
        .out_sync    (out_sync),
        .in0selected (in0selected),
        .bit_counter (bit_counter),
        .frame_error (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the capturing edge
    task automatic step(input logic dd, input logic dc, input logic ds,
                        input logic bd, input logic bc, input logic bs);
        @(negedge clk);
        din_data = dd; din_clk = dc; din_sync = ds;
        bin_data = bd; bin_clk = bc; bin_sync = bs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_data, out_clk, out_sync, in0selected, frame_error, bit_counter} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", {out_data, out_clk, out_sync, in0selected, frame_error, bit_counter});
        end
    endtask

    task automatic test_din_only();
        logic d;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            d = i[0] ^ i[2];
            step(d, 1, 1, 0, 0, 0);
            checks++;
            if ({out_clk, out_sync, in0selected, out_data} !== {1'b1, 1'b1, 1'b1, d}) begin
                errors++;
                $display("FAIL din_strobe%0d clk/sync/in0/data got=%b exp=%b", i, {out_clk, out_sync, in0selected, out_data}, {1'b1, 1'b1, 1'b1, d});
            end
            checks++;
            if (bit_counter !== 5'(i % 32)) begin
                errors++;
                $display("FAIL din_bitcnt%0d got=%0d exp=%0d", i, bit_counter, i % 32);
            end
            // Gap cycle: no strobe, counter and data hold
            step(0, 0, 1, 0, 0, 0);
            checks++;
            if ({out_clk, out_sync, out_data, bit_counter} !== {1'b0, 1'b1, d, 5'(i % 32)}) begin
                errors++;
                $display("FAIL din_gap%0d clk/sync/data/cnt got=%b exp=%b", i, {out_clk, out_sync, out_data, bit_counter}, {1'b0, 1'b1, d, 5'(i % 32)});
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, 1, 1, 0, 1, 1);
        checks++;
        if ({out_clk, out_data, in0selected, bit_counter} !== {1'b1, 1'b1, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL simul_start got=%b exp=%b", {out_clk, out_data, in0selected, bit_counter}, {1'b1, 1'b1, 1'b1, 5'd0});
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 1, 1);
            checks++;
            if ({out_clk, out_sync, in0selected, out_data} !== 4'b0111) begin
                errors++;
                $display("FAIL simul_bin_ignored%0d got=%b exp=0111", i, {out_clk, out_sync, in0selected, out_data});
            end
        end
    endtask

    task automatic test_bin_sync_drop();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 1, 1);
            checks++;
            if ({out_clk, out_sync, in0selected, bit_counter} !== {1'b1, 1'b1, 1'b0, 5'(i)}) begin
                errors++;
                $display("FAIL bin_strobe%0d got=%b exp=%b", i, {out_clk, out_sync, in0selected, bit_counter}, {1'b1, 1'b1, 1'b0, 5'(i)});
            end
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if ({frame_error, out_sync, out_clk, bit_counter} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL bin_drop_ferr got=%b exp=%b", {frame_error, out_sync, out_clk, bit_counter}, {1'b1, 1'b0, 1'b0, 5'd0});
        end
        // 16 HOLD cycles: DIN strobes are dropped
        for (int i = 1; i <= 16; i++) begin
            step(1, 1, 1, 0, 0, 0);
            checks++;
            if ({out_clk, out_sync, in0selected, frame_error} !== 4'b0000) begin
                errors++;
                $display("FAIL hold_cycle%0d clk/sync/in0/ferr got=%b exp=0000", i, {out_clk, out_sync, in0selected, frame_error});
            end
        end
        // Cycle 17 is IDLE: DIN strobe locks
        step(1, 1, 1, 0, 0, 0);
        checks++;
        if ({out_clk, out_sync, in0selected, out_data, bit_counter} !== {4'b1111, 5'd0}) begin
            errors++;
            $display("FAIL relock_din got=%b exp=%b", {out_clk, out_sync, in0selected, out_data, bit_counter}, {4'b1111, 5'd0});
        end
    endtask

    task automatic test_idle_timeout();
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 1, 1, 0, 0, 0);
        checks++;
        if (bit_counter !== 5'd31) begin
            errors++;
            $display("FAIL timeout_last_bit got=%0d exp=31", bit_counter);
        end
        for (int k = 1; k <= 255; k++) begin
            step(0, 0, 1, 0, 0, 0);
            if (k == 254) begin
                checks++;
                if ({out_sync, in0selected} !== 2'b11) begin
                    errors++;
                    $display("FAIL timeout_early got=%b exp=11", {out_sync, in0selected});
                end
            end
        end
        checks++;
        if ({out_sync, in0selected, frame_error, bit_counter} !== {3'b000, 5'd0}) begin
            errors++;
            $display("FAIL timeout_release got=%b exp=%b", {out_sync, in0selected, frame_error, bit_counter}, {3'b000, 5'd0});
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
        rst = 1'b1;
        step(1, 1, 1, 0, 0, 0);
        rst = 1'b0;
        checks++;
        if ({out_data, out_clk, out_sync, in0selected, frame_error, bit_counter} !== 10'd0) begin
            errors++;
            $display("FAIL midword_reset got=%b exp=0", {out_data, out_clk, out_sync, in0selected, frame_error, bit_counter});
        end
        step(1, 1, 1, 0, 0, 0);
        checks++;
        if ({out_clk, in0selected, frame_error, bit_counter} !== {3'b110, 5'd0}) begin
            errors++;
            $display("FAIL midword_relock got=%b exp=%b", {out_clk, in0selected, frame_error, bit_counter}, {3'b110, 5'd0});
        end
    endtask

    task automatic test_drop_with_strobe();
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        checks++;
        if ({out_clk, out_sync, frame_error, bit_counter} !== {3'b001, 5'd0}) begin
            errors++;
            $display("FAIL drop_strobe got=%b exp=%b", {out_clk, out_sync, frame_error, bit_counter}, {3'b001, 5'd0});
        end
        checks++;
        if (out_data !== 1'b0) begin
            errors++;
            $display("FAIL drop_strobe_data got=%b exp=0", out_data);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, 1, 1);
            checks++;
            if ({out_clk, out_sync, frame_error, bit_counter} !== 8'd0) begin
                errors++;
                $display("FAIL hold_strobe%0d got=%b exp=0", i, {out_clk, out_sync, frame_error, bit_counter});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        din_data = 0; din_clk = 0; din_sync = 0;
        bin_data = 0; bin_clk = 0; bin_sync = 0;
        test_reset();
        test_din_only();
        test_simultaneous();
        test_bin_sync_drop();
        test_idle_timeout();
        test_reset_mid_word();
        test_drop_with_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
